pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the five-stage pipeline latches: PC, F/D, D/X, X/M and M/W.
- Drives every latch enable plus the NOP-insertion selects for F/D and D/X.
- Sequences the multi-cycle mult/div unit: start pulse, freeze, result capture, timeout.
- Detects load-use hazards and taken-branch flushes; keeps a saturating stall-cycle counter for debug.

---
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline latches.
// Resolves mult/div freezes, taken-branch flushes and load-use stalls, and counts stall cycles.
module pipe_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       fd_rs,
  input  logic [4:0]       fd_rt,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  input  logic             dx_is_load,
  input  logic [4:0]       dx_rd,
  input  logic             x_is_multdiv,
  input  logic             x_branch_taken,
  input  logic             md_result_rdy,
  output logic             en_pc,
  output logic             en_fd,
  output logic             en_dx,
  output logic             en_xm,
  output logic             en_mw,
  output logic             flush_fd,
  output logic             flush_dx,
  output logic             bubble_mw,
  output logic             pc_sel_branch,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} state_t;

  state_t             state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic               err_set;
  logic               md_error_q;
  logic [CNT_W-1:0]   stall_count_q;
  logic               load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign load_use = dx_is_load && (dx_rd != 5'd0) &&
                    ((fd_uses_rs && (fd_rs == dx_rd)) || (fd_uses_rt && (fd_rt == dx_rd)));

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    err_set       = 1'b0;
    en_pc         = 1'b1;
    en_fd         = 1'b1;
    en_dx         = 1'b1;
    en_xm         = 1'b1;
    en_mw         = 1'b1;
    flush_fd      = 1'b0;
    flush_dx      = 1'b0;
    bubble_mw     = 1'b0;
    pc_sel_branch = 1'b0;
    md_start      = 1'b0;
    md_busy       = 1'b0;

    case (state)
      RUN: begin
        if (x_is_multdiv) begin
          md_start  = 1'b1;
          en_pc     = 1'b0;
          en_fd     = 1'b0;
          en_dx     = 1'b0;
          en_xm     = 1'b0;
          bubble_mw = 1'b1;
          state_nxt = MD_BUSY;
        end else if (x_branch_taken) begin
          // Younger insns are squashed, so a pending load-use hit no longer matters.
          pc_sel_branch = 1'b1;
          flush_fd      = 1'b1;
          flush_dx      = 1'b1;
        end else if (load_use) begin
          en_pc    = 1'b0;
          en_fd    = 1'b0;
          flush_dx = 1'b1;
        end
      end
      MD_BUSY: begin
        en_pc        = 1'b0;
        en_fd        = 1'b0;
        en_dx        = 1'b0;
        en_xm        = 1'b0;
        bubble_mw    = 1'b1;
        md_busy      = 1'b1;
        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        if (md_result_rdy) begin
          state_nxt = MD_DONE;
        end else if (wait_cnt == WAIT_W'(MD_TIMEOUT - 1)) begin
          err_set   = 1'b1;
          state_nxt = MD_DONE;
        end
      end
      MD_DONE: begin
        // Capture cycle: the mul/div is still in X, so it must not restart here.
        wait_cnt_nxt = '0;
        state_nxt    = RUN;
      end
      default: begin
        wait_cnt_nxt = '0;
        state_nxt    = RUN;
      end
    endcase

    if (reset) begin
      en_pc         = 1'b0;
      en_fd         = 1'b0;
      en_dx         = 1'b0;
      en_xm         = 1'b0;
      en_mw         = 1'b0;
      flush_fd      = 1'b0;
      flush_dx      = 1'b0;
      bubble_mw     = 1'b0;
      pc_sel_branch = 1'b0;
      md_start      = 1'b0;
      md_busy       = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      wait_cnt      <= '0;
      md_error_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (err_set) begin
        md_error_q <= 1'b1;
      end
      if (!en_pc) begin
        stall_count_q <= sat_inc(stall_count_q);
      end
    end
  end

  assign md_error    = md_error_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle comparison against a behavioural
// model of the hazard rules, plus directed scenarios with hand-computed literals.
module tb_pipe_hazard_ctrl;

  localparam int MD_TIMEOUT = 64;
  localparam int CNT_W      = 8;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       fd_rs, fd_rt, dx_rd;
  logic             fd_uses_rs, fd_uses_rt, dx_is_load;
  logic             x_is_multdiv, x_branch_taken, md_result_rdy;
  logic             en_pc, en_fd, en_dx, en_xm, en_mw;
  logic             flush_fd, flush_dx, bubble_mw, pc_sel_branch;
  logic             md_start, md_busy, md_error;
  logic [CNT_W-1:0] stall_count;

  typedef struct packed {
    logic en_pc, en_fd, en_dx, en_xm, en_mw;
    logic flush_fd, flush_dx, bubble_mw, pc_sel_branch;
    logic md_start, md_busy, md_error;
  } outs_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: m_wait < 0 means no mul/div outstanding, otherwise busy cycles already spent.
  int     m_wait   = -1;
  bit     m_done   = 1'b0;
  bit     m_err    = 1'b0;
  longint m_stalls = 0;

  pipe_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
    .dx_is_load(dx_is_load), .dx_rd(dx_rd),
    .x_is_multdiv(x_is_multdiv), .x_branch_taken(x_branch_taken),
    .md_result_rdy(md_result_rdy),
    .en_pc(en_pc), .en_fd(en_fd), .en_dx(en_dx), .en_xm(en_xm), .en_mw(en_mw),
    .flush_fd(flush_fd), .flush_dx(flush_dx), .bubble_mw(bubble_mw),
    .pc_sel_branch(pc_sel_branch), .md_start(md_start), .md_busy(md_busy),
    .md_error(md_error), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic outs_t dut_outs();
    return {en_pc, en_fd, en_dx, en_xm, en_mw, flush_fd, flush_dx, bubble_mw,
            pc_sel_branch, md_start, md_busy, md_error};
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    bit    hit;
    o = '0;
    if (reset) return o;
    hit = dx_is_load && (dx_rd != 0) &&
          ((fd_uses_rs && fd_rs == dx_rd) || (fd_uses_rt && fd_rt == dx_rd));
    o.md_error = m_err;
    if (m_wait >= 0) begin
      o.en_mw = 1; o.bubble_mw = 1; o.md_busy = 1;
    end else if (m_done) begin
      {o.en_pc, o.en_fd, o.en_dx, o.en_xm, o.en_mw} = 5'b11111;
    end else if (x_is_multdiv) begin
      o.en_mw = 1; o.bubble_mw = 1; o.md_start = 1;
    end else if (x_branch_taken) begin
      {o.en_pc, o.en_fd, o.en_dx, o.en_xm, o.en_mw} = 5'b11111;
      o.pc_sel_branch = 1; o.flush_fd = 1; o.flush_dx = 1;
    end else if (hit) begin
      o.en_dx = 1; o.en_xm = 1; o.en_mw = 1; o.flush_dx = 1;
    end else begin
      {o.en_pc, o.en_fd, o.en_dx, o.en_xm, o.en_mw} = 5'b11111;
    end
    return o;
  endfunction

  // Model advance on each clock edge, cleared by reset.
  initial forever begin
    outs_t o;
    @(posedge clock or posedge reset);
    if (reset) begin
      m_wait = -1; m_done = 0; m_err = 0; m_stalls = 0;
    end else begin
      o = model_outs();
      if (!o.en_pc && m_stalls < CNT_MAX) m_stalls++;
      if (m_wait >= 0) begin
        if (md_result_rdy || m_wait == MD_TIMEOUT - 1) begin
          if (!md_result_rdy) m_err = 1;
          m_wait = -1;
          m_done = 1;
        end else begin
          m_wait++;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (x_is_multdiv) begin
        m_wait = 0;
      end
    end
  end

  // Per-cycle comparison, mid-cycle.
  initial forever begin
    @(negedge clock);
    check("outputs", 64'(dut_outs()), 64'(model_outs()));
    check("stall_count", 64'(stall_count), 64'(m_stalls));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    fd_rs = 0; fd_rt = 0; dx_rd = 0;
    fd_uses_rs = 0; fd_uses_rt = 0; dx_is_load = 0;
    x_is_multdiv = 0; x_branch_taken = 0; md_result_rdy = 0;
  endtask

  initial begin
    int starts, busys, lows;
    outs_t o;
    reset = 1'b1;
    clear_inputs();
    @(posedge clock);
    #2;
    check("reset_outs", 64'(dut_outs()), 64'd0);
    check("reset_cnt", 64'(stall_count), 64'd0);
    tick();
    reset = 1'b0;

    // Quiet pipeline
    repeat (10) tick();
    check("idle_en", 64'({en_pc, en_fd, en_dx, en_xm, en_mw, flush_fd, flush_dx, bubble_mw}), 64'hF8);
    check("idle_cnt", 64'(stall_count), 64'd0);

    // Load-use on rs
    dx_is_load = 1; dx_rd = 5; fd_rs = 5; fd_uses_rs = 1;
    @(negedge clock);
    check("lu_rs_stall", 64'({en_pc, en_fd, en_dx, flush_dx}), 64'b0011);
    tick();
    clear_inputs();
    @(negedge clock);
    check("lu_rs_after", 64'({en_pc, en_fd, flush_dx}), 64'b110);
    check("lu_rs_cnt", 64'(stall_count), 64'd1);
    tick();

    // Load into r0 never stalls
    dx_is_load = 1; dx_rd = 0; fd_rs = 0; fd_uses_rs = 1;
    @(negedge clock);
    check("lu_r0", 64'({en_pc, flush_dx}), 64'b10);
    tick();

    // Load-use on rt
    clear_inputs();
    dx_is_load = 1; dx_rd = 9; fd_rs = 9; fd_rt = 9; fd_uses_rt = 1;
    @(negedge clock);
    check("lu_rt_stall", 64'(en_pc), 64'd0);
    tick();

    // Matching register fields but not read
    clear_inputs();
    dx_is_load = 1; dx_rd = 9; fd_rs = 9; fd_rt = 9;
    @(negedge clock);
    check("lu_unused", 64'(en_pc), 64'd1);
    check("lu_rt_cnt", 64'(stall_count), 64'd2);
    tick();

    // Stray result pulse in RUN
    clear_inputs();
    md_result_rdy = 1;
    tick();
    md_result_rdy = 0;

    // Mul/div finishing on the 17th busy cycle
    starts = 0; busys = 0; lows = 0;
    x_is_multdiv = 1;
    for (int c = 0; c < 19; c++) begin
      md_result_rdy = (c == 17);
      @(negedge clock);
      starts += int'(md_start);
      busys  += int'(md_busy);
      lows   += int'(!en_pc);
      if (c == 18)
        check("md_done_en", 64'({en_pc, en_fd, en_dx, en_xm, en_mw, md_start, bubble_mw}), 64'h7C);
      tick();
    end
    md_result_rdy = 0;
    x_is_multdiv  = 0;
    check("md_starts", 64'(starts), 64'd1);
    check("md_busys", 64'(busys), 64'd17);
    check("md_stall_cycles", 64'(lows), 64'd18);
    @(negedge clock);
    check("md_cnt", 64'(stall_count), 64'd20);
    tick();

    // Taken branch concurrent with a load-use hit
    x_branch_taken = 1; dx_is_load = 1; dx_rd = 7; fd_rs = 7; fd_uses_rs = 1;
    @(negedge clock);
    check("br_lu", 64'({pc_sel_branch, flush_fd, flush_dx, en_pc, en_fd}), 64'h1F);
    tick();
    clear_inputs();
    @(negedge clock);
    check("br_cnt", 64'(stall_count), 64'd20);
    tick();

    // Timeout with no result
    x_is_multdiv = 1;
    for (int c = 0; c < 66; c++) begin
      @(negedge clock);
      if (c == 64) check("to_last_busy", 64'({md_busy, md_error}), 64'b10);
      if (c == 65) check("to_done", 64'({md_busy, md_error, md_start, en_pc, en_xm}), 64'b01011);
      tick();
    end
    x_is_multdiv = 0;
    repeat (5) tick();
    @(negedge clock);
    check("to_sticky", 64'(md_error), 64'd1);
    check("to_cnt", 64'(stall_count), 64'd85);
    tick();

    // Reset during the 5th busy cycle
    x_is_multdiv = 1;
    repeat (5) tick();
    #2;
    check("rst_pre_busy", 64'(md_busy), 64'd1);
    reset = 1'b1;
    #1;
    o = dut_outs();
    check("rst_async_outs", 64'(o), 64'd0);
    check("rst_async_cnt", 64'(stall_count), 64'd0);
    x_is_multdiv = 0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_after", 64'({md_busy, md_start, md_error, en_pc}), 64'b0001);
    tick();

    // Back-to-back timeouts drive stall_count into saturation
    for (int k = 0; k < 4; k++) begin
      x_is_multdiv = 1;
      if (k == 0) begin
        @(negedge clock);
        check("fresh_start", 64'(md_start), 64'd1);
      end
      repeat (66) tick();
      x_is_multdiv = 0;
      tick();
    end
    @(negedge clock);
    check("sat_cnt", 64'(stall_count), 64'(CNT_MAX));
    check("sat_err", 64'(md_error), 64'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
